// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared widths, opcode table, op enum and decoded entry type for the SIMD decode stage
package simd_pkg;

    localparam int NUM_WARPS = 4;
    localparam int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int REG_W     = 5;
    localparam int ADDR_W    = 9;
    localparam int IMM_W     = 12;
    localparam int SHAMT_W   = 6;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_MUL     = 4'd2,
        OP_UDIV    = 4'd3,
        OP_FADD    = 4'd4,
        OP_FSUB    = 4'd5,
        OP_LOAD    = 4'd6,
        OP_RET     = 4'd7,
        OP_ADDI    = 4'd8,
        OP_SUBI    = 4'd9,
        OP_ILLEGAL = 4'd15
    } op_e;

    // Primary opcodes live in instr[31:21]; the immediate forms only use instr[31:22].
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_MUL  = 11'b10011011000;
    localparam logic [10:0] OPC_UDIV = 11'b10011010110;
    localparam logic [10:0] OPC_FP   = 11'b00011110011;
    localparam logic [10:0] OPC_LOAD = 11'b10101010101;
    localparam logic [10:0] OPC_RET  = 11'b11010110010;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;

    // FP add/sub share OPC_FP and are told apart by instr[15:10].
    localparam logic [5:0]  FP_ADD_FN = 6'b001010;
    localparam logic [5:0]  FP_SUB_FN = 6'b001110;

    typedef struct packed {
        op_e                op;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [SHAMT_W-1:0] shamt;
        logic [IMM_W-1:0]   imm;
        logic [ADDR_W-1:0]  addr;
        logic [WID_W-1:0]   wid;
    } decoded_t;

endpackage

// File: rtl/simd_decode_comb.sv
// rtl/simd_decode_comb.sv - pure combinational instruction word to decoded entry (warp id left zero)
module simd_decode_comb
    import simd_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);

    op_e op;

    always_comb begin
        op = OP_ILLEGAL;
        case (instr[31:21])
            OPC_ADD:  op = OP_ADD;
            OPC_SUB:  op = OP_SUB;
            OPC_MUL:  op = OP_MUL;
            OPC_UDIV: op = OP_UDIV;
            OPC_LOAD: op = OP_LOAD;
            OPC_RET:  op = OP_RET;
            OPC_FP: begin
                if (instr[15:10] == FP_ADD_FN) begin
                    op = OP_FADD;
                end else if (instr[15:10] == FP_SUB_FN) begin
                    op = OP_FSUB;
                end
            end
            default: begin
                if (instr[31:22] == OPC_ADDI) begin
                    op = OP_ADDI;
                end else if (instr[31:22] == OPC_SUBI) begin
                    op = OP_SUBI;
                end
            end
        endcase
    end

    // Operand fields are filled for every op so downstream never sees stale junk.
    always_comb begin
        dec       = '0;
        dec.op    = op;
        dec.rd    = REG_W'(instr[4:0]);
        dec.rs1   = REG_W'(instr[9:5]);
        dec.rs2   = REG_W'(instr[20:16]);
        dec.shamt = instr[15:10];
        dec.imm   = instr[10 +: IMM_W];
        dec.addr  = instr[12 +: ADDR_W];
        dec.wid   = '0;
    end

endmodule

// File: rtl/simd_decode_stage.sv
// rtl/simd_decode_stage.sv - registered decode stage with 2-entry output queue and sticky status flags
module simd_decode_stage
    import simd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [WID_W-1:0]     in_wid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output decoded_t             out_dec,
    output logic                 illegal_err,
    output logic [NUM_WARPS-1:0] ret_mask
);

    decoded_t   dec_c;
    decoded_t   push_entry;
    decoded_t   mem [2];
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;

    simd_decode_comb u_decode (
        .instr (in_instr),
        .dec   (dec_c)
    );

    always_comb begin
        push_entry     = dec_c;
        push_entry.wid = in_wid;
    end

    assign out_valid = (count != 2'd0);
    assign out_dec   = mem[rd_ptr];

    // A full queue still accepts when the head leaves this cycle, keeping 1 instr/cycle.
    assign in_ready  = !rst && ((count < 2'd2) || out_ready);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            mem[0]      <= '0;
            mem[1]      <= '0;
            illegal_err <= 1'b0;
            ret_mask    <= '0;
        end else begin
            // A head popped in a flush cycle was really consumed, so it still marks RET.
            if (pop && (out_dec.op == OP_RET)) begin
                ret_mask[out_dec.wid] <= 1'b1;
            end
            if (flush) begin
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= push_entry;
                    wr_ptr      <= ~wr_ptr;
                    if (push_entry.op == OP_ILLEGAL) begin
                        illegal_err <= 1'b1;
                    end
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + 2'(push) - 2'(pop);
            end
        end
    end

endmodule

// File: tb/tb_simd_decode_stage.sv
// tb/tb_simd_decode_stage.sv - directed plus randomized bench with a queue-based reference model
module tb_simd_decode_stage;
    import simd_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [31:0]          in_instr = '0;
    logic [WID_W-1:0]     in_wid = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    decoded_t             out_dec;
    logic                 illegal_err;
    logic [NUM_WARPS-1:0] ret_mask;

    int checks = 0;
    int failures = 0;

    decoded_t             mq[$];
    logic                 m_ill = 1'b0;
    logic [NUM_WARPS-1:0] m_rmask = '0;

    // Encoding table: a word decodes to op when (word & mask) == match.
    logic [31:0] r_mask  [10] = '{32'hFFE00000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000,
                                  32'hFFE0FC00, 32'hFFE0FC00, 32'hFFE00000, 32'hFFE00000,
                                  32'hFFC00000, 32'hFFC00000};
    logic [31:0] r_match [10] = '{32'h8B000000, 32'hCB000000, 32'h9B000000, 32'h9AC00000,
                                  32'h1E602800, 32'h1E603800, 32'hAAA00000, 32'hD6400000,
                                  32'h91000000, 32'hD1000000};
    logic [3:0]  r_op    [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

    simd_decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_wid      (in_wid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_dec     (out_dec),
        .illegal_err (illegal_err),
        .ret_mask    (ret_mask)
    );

    always #5 clk = ~clk;

    function automatic decoded_t ref_decode(input logic [31:0] w, input logic [WID_W-1:0] wid);
        decoded_t    d;
        int unsigned u;
        u       = w;
        d.op    = OP_ILLEGAL;
        for (int k = 0; k < 10; k++) begin
            if ((w & r_mask[k]) == r_match[k]) begin
                d.op = op_e'(r_op[k]);
                break;
            end
        end
        d.rd    = REG_W'(u % 32);
        d.rs1   = REG_W'((u / 32) % 32);
        d.rs2   = REG_W'((u / 65536) % 32);
        d.shamt = 6'((u / 1024) % 64);
        d.imm   = IMM_W'((u / 1024) % 4096);
        d.addr  = ADDR_W'((u / 4096) % 512);
        d.wid   = wid;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic v, input logic [31:0] ins,
                       input logic [WID_W-1:0] w, input logic ordy);
        logic     rdy_m;
        logic     pop_m;
        logic     push_m;
        decoded_t d;
        @(negedge clk);
        rst = r;
        flush = f;
        in_valid = v;
        in_instr = ins;
        in_wid = w;
        out_ready = ordy;
        #1;
        rdy_m = !r && ((mq.size() < 2) || ordy);
        chk("in_ready", 64'(in_ready), 64'(rdy_m));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) chk("out_dec", 64'(out_dec), 64'(mq[0]));
        chk("illegal_err", 64'(illegal_err), 64'(m_ill));
        chk("ret_mask", 64'(ret_mask), 64'(m_rmask));
        if (r) begin
            mq.delete();
            m_ill = 1'b0;
            m_rmask = '0;
        end else begin
            pop_m = (mq.size() != 0) && ordy;
            push_m = v && rdy_m && !f;
            if (pop_m && (mq[0].op == OP_RET)) m_rmask[mq[0].wid] = 1'b1;
            if (f) begin
                mq.delete();
            end else begin
                if (pop_m) void'(mq.pop_front());
                if (push_m) begin
                    d = ref_decode(ins, w);
                    mq.push_back(d);
                    if (d.op == OP_ILLEGAL) m_ill = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int unsigned k;
        k = $urandom_range(0, 11);
        if (k < 10) return r_match[k] | ($urandom & ~r_mask[k]);
        return $urandom;
    endfunction

    initial begin
        cyc(1, 0, 0, 32'h0, 0, 0);
        cyc(1, 0, 1, 32'h8B020020, 0, 1);
        cyc(0, 0, 0, 32'h0, 0, 1);
        chk("reset_out_dec", 64'(out_dec), 64'd0);

        cyc(0, 0, 1, 32'h8B020020, 0, 1);
        cyc(0, 0, 1, 32'h1E622820, 1, 1);
        cyc(0, 0, 0, 32'h0, 0, 1);
        cyc(0, 0, 0, 32'h0, 0, 1);

        cyc(0, 0, 1, 32'h91000C21, 0, 1);
        cyc(0, 0, 1, 32'hFFFFFFFF, 3, 1);
        cyc(0, 0, 0, 32'h0, 0, 1);
        cyc(0, 0, 0, 32'h0, 0, 1);
        chk("illegal_sticky", 64'(illegal_err), 64'd1);

        cyc(0, 0, 1, 32'hCB030041, 1, 0);
        cyc(0, 0, 1, 32'h9B040062, 2, 0);
        cyc(0, 0, 1, 32'h9AC50083, 3, 0);
        cyc(0, 0, 1, 32'h9AC50083, 3, 1);
        cyc(0, 0, 0, 32'h0, 0, 1);
        cyc(0, 0, 0, 32'h0, 0, 1);
        cyc(0, 0, 0, 32'h0, 0, 1);

        cyc(0, 0, 1, 32'hAAA12345, 0, 0);
        cyc(0, 0, 1, 32'h8B020020, 1, 0);
        cyc(0, 1, 1, 32'h1E623820, 2, 0);
        cyc(0, 0, 0, 32'h0, 0, 1);
        chk("flush_empty", 64'(out_valid), 64'd0);

        cyc(0, 0, 1, 32'hD65F03C0, 2, 0);
        cyc(0, 0, 0, 32'h0, 0, 1);
        cyc(0, 0, 0, 32'h0, 0, 1);
        chk("ret_mask_pop", 64'(ret_mask), 64'h4);
        cyc(0, 0, 1, 32'hD65F03C0, 3, 0);
        cyc(0, 1, 0, 32'h0, 0, 0);
        cyc(0, 0, 0, 32'h0, 0, 1);
        chk("ret_mask_flushed", 64'(ret_mask), 64'h4);

        cyc(0, 0, 1, 32'h8B020020, 0, 0);
        cyc(0, 0, 1, 32'hFFFFFFFF, 1, 0);
        cyc(1, 1, 1, 32'hD65F03C0, 1, 1);
        cyc(0, 0, 0, 32'h0, 0, 1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_flags", 64'({illegal_err, ret_mask}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0), rand_instr(), WID_W'($urandom),
                ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
